music_player_core: RTL and testbench

MUSIC_PLAYER_CORE -- requirements
Module: music_player_core

---
 rtl/music_player_core_if.sv | 38 +++
 rtl/music_player_core.sv | 164 ++++++++++++++++
 tb/tb_music_player_core.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/music_player_core_if.sv
// Bus bundle for the music player core: transport controls, song selection,
// voice sample inputs and the codec/reader-facing outputs.
interface music_player_core_if #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 16,
  parameter int SONG_W     = 4
);
  logic                             play_button;
  logic                             next_button;
  logic [SONG_W-1:0]                song_select;
  logic                             song_select_valid;
  logic                             loop_en;
  logic                             song_done;
  logic                             new_frame;
  logic [NUM_VOICES*SAMPLE_W-1:0]   voice_sample;
  logic [NUM_VOICES-1:0]            voice_ready;
  logic                             play;
  logic                             reset_player;
  logic [SONG_W-1:0]                song;
  logic                             beat;
  logic                             generate_next_sample;
  logic                             new_sample_generated;
  logic signed [SAMPLE_W-1:0]       sample_out;

  modport master (
    output play_button, next_button, song_select, song_select_valid, loop_en,
           song_done, new_frame, voice_sample, voice_ready,
    input  play, reset_player, song, beat, generate_next_sample,
           new_sample_generated, sample_out
  );

  modport slave (
    input  play_button, next_button, song_select, song_select_valid, loop_en,
           song_done, new_frame, voice_sample, voice_ready,
    output play, reset_player, song, beat, generate_next_sample,
           new_sample_generated, sample_out
  );
endinterface

// File: rtl/music_player_core.sv
// Music player core: transport FSM with song sequencing, frame strobe edge
// detection, beat counter and a saturating multi-voice sample mixer.
module music_player_core #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 16,
  parameter int SONG_W     = 4,
  parameter int NUM_SONGS  = 16,
  parameter int BEAT_COUNT = 1000
) (
  input  logic                clk,
  input  logic                reset,
  music_player_core_if.slave  bus
);

  localparam int SUM_W  = SAMPLE_W + $clog2(NUM_VOICES);
  localparam int BEAT_W = (BEAT_COUNT > 1) ? $clog2(BEAT_COUNT) : 1;
  localparam logic [BEAT_W-1:0]       BEAT_LAST = BEAT_W'(BEAT_COUNT - 1);
  localparam logic signed [SUM_W-1:0] SAT_MAX   = SUM_W'((2 ** (SAMPLE_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN   = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, PLAYING, PAUSED, RESTART} state_t;

  state_t                     state_q, state_d;
  state_t                     ret_q, ret_d;
  logic [SONG_W-1:0]          song_q, song_d;
  logic [SONG_W-1:0]          song_inc;
  logic                       sel_ok;
  logic                       playing;

  logic                       nf_q;
  logic                       gen_q;
  logic [BEAT_W-1:0]          beat_cnt_q;

  logic signed [SAMPLE_W-1:0] smp_p0 [NUM_VOICES];
  logic [NUM_VOICES-1:0]      mask_p0;
  logic                       mix_fire;
  logic signed [SUM_W-1:0]    sum_p0;
  logic signed [SAMPLE_W-1:0] mix_p1;
  logic                       vld_p1;
  logic signed [SAMPLE_W-1:0] sample_out_q;

  function automatic logic signed [SAMPLE_W-1:0] sat(input logic signed [SUM_W-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[SAMPLE_W-1:0];
    else if (v < SAT_MIN) return SAT_MIN[SAMPLE_W-1:0];
    else                  return v[SAMPLE_W-1:0];
  endfunction

  assign sel_ok   = (int'(bus.song_select) < NUM_SONGS);
  assign song_inc = (int'(song_q) == NUM_SONGS - 1) ? '0 : song_q + 1'b1;
  assign playing  = (state_q == PLAYING);

  // Transport next-state: one event per cycle, highest priority wins even if it turns out invalid.
  always_comb begin
    state_d = (state_q == RESTART) ? ret_q : state_q;
    ret_d   = ret_q;
    song_d  = song_q;
    if (bus.song_select_valid) begin
      if (sel_ok) begin
        song_d  = bus.song_select;
        state_d = RESTART;
        ret_d   = PLAYING;
      end
    end else if (bus.next_button) begin
      song_d  = song_inc;
      state_d = RESTART;
      ret_d   = IDLE;
    end else if (bus.song_done && playing) begin
      if (!bus.loop_en) song_d = song_inc;
      state_d = RESTART;
      ret_d   = bus.loop_en ? PLAYING : IDLE;
    end else if (bus.play_button && state_q != RESTART) begin
      case (state_q)
        IDLE:    state_d = PLAYING;
        PLAYING: state_d = PAUSED;
        PAUSED:  state_d = PLAYING;
        default: state_d = state_q;
      endcase
    end
  end

  // Transport state, restart target and current song registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ret_q   <= IDLE;
      song_q  <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      song_q  <= song_d;
    end
  end

  // Frame strobe rising-edge detect; one pulse per low-to-high transition.
  always_ff @(posedge clk) begin
    if (!reset) begin
      nf_q  <= 1'b0;
      gen_q <= 1'b0;
    end else begin
      nf_q  <= bus.new_frame;
      gen_q <= bus.new_frame && !nf_q;
    end
  end

  // Beat counter advances on frame pulses only while playing; restart zeroes it.
  always_ff @(posedge clk) begin
    if (!reset || state_q == RESTART) begin
      beat_cnt_q <= '0;
    end else if (gen_q && playing) begin
      beat_cnt_q <= (beat_cnt_q == BEAT_LAST) ? '0 : beat_cnt_q + 1'b1;
    end
  end

  // Stage p0: per-voice sample capture; a repeated ready pulse overwrites.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (bus.voice_ready[i]) smp_p0[i] <= $signed(bus.voice_sample[i*SAMPLE_W +: SAMPLE_W]);
    end
  end

  assign mix_fire = &mask_p0;

  // Wide signed sum of all captured voices.
  always_comb begin
    sum_p0 = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      sum_p0 = sum_p0 + SUM_W'(smp_p0[i]);
    end
  end

  // Stage p1: saturated mix result held as pending for the next frame.
  always_ff @(posedge clk) begin
    if (mix_fire) mix_p1 <= sat(sum_p0);
  end

  // Mixer control: ready mask, pending flag and codec output; a mix landing on a frame pulse stays pending.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mask_p0      <= '0;
      vld_p1       <= 1'b0;
      sample_out_q <= '0;
    end else begin
      if (gen_q && vld_p1) begin
        sample_out_q <= mix_p1;
        vld_p1       <= 1'b0;
      end
      if (mix_fire) vld_p1 <= 1'b1;
      mask_p0 <= (mix_fire ? '0 : mask_p0) | bus.voice_ready;
      if (state_q == RESTART) begin
        mask_p0 <= '0;
        vld_p1  <= 1'b0;
      end
    end
  end

  assign bus.play                 = playing;
  assign bus.reset_player         = (state_q == RESTART);
  assign bus.song                 = song_q;
  assign bus.beat                 = gen_q && playing && (beat_cnt_q == BEAT_LAST);
  assign bus.generate_next_sample = gen_q;
  assign bus.new_sample_generated = gen_q;
  assign bus.sample_out           = sample_out_q;

endmodule

// File: tb/tb_music_player_core.sv
// Directed bench for music_player_core: transport, beat, mixer and reset.
module tb_music_player_core;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   errors  = 0;

  music_player_core_if #(.NUM_VOICES(4), .SAMPLE_W(16), .SONG_W(5)) bus ();

  music_player_core #(
    .NUM_VOICES(4), .SAMPLE_W(16), .SONG_W(5), .NUM_SONGS(16), .BEAT_COUNT(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame();
    bus.new_frame = 1'b1;
    step();
    bus.new_frame = 1'b0;
    step();
  endtask

  task automatic set_voices(input logic signed [15:0] v0, v1, v2, v3);
    bus.voice_sample = {v3, v2, v1, v0};
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    vectors++; if (bus.play !== 1'b0) begin errors++; $display("FAIL reset_play got=%0b exp=0", bus.play); end
    vectors++; if (bus.song !== 5'd0) begin errors++; $display("FAIL reset_song got=%0d exp=0", bus.song); end
    vectors++; if (bus.reset_player !== 1'b0) begin errors++; $display("FAIL reset_rp got=%0b exp=0", bus.reset_player); end
    vectors++; if (bus.generate_next_sample !== 1'b0 || bus.beat !== 1'b0) begin errors++; $display("FAIL reset_gen_beat got=%0b%0b exp=00", bus.generate_next_sample, bus.beat); end
    vectors++; if (bus.sample_out !== 16'sd0) begin errors++; $display("FAIL reset_sample got=%0d exp=0", bus.sample_out); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_beat();
    bus.play_button = 1'b1; step(); bus.play_button = 1'b0;
    vectors++; if (bus.play !== 1'b1) begin errors++; $display("FAIL beat_play got=%0b exp=1", bus.play); end
    for (int f = 1; f <= 8; f++) begin
      bus.new_frame = 1'b1; step(); bus.new_frame = 1'b0;
      vectors++; if (bus.generate_next_sample !== 1'b1) begin errors++; $display("FAIL beat_gen f=%0d got=0 exp=1", f); end
      vectors++; if (bus.beat !== ((f % 4) == 0)) begin errors++; $display("FAIL beat_pulse f=%0d got=%0b exp=%0b", f, bus.beat, (f % 4) == 0); end
      step();
      vectors++; if (bus.beat !== 1'b0 || bus.generate_next_sample !== 1'b0) begin errors++; $display("FAIL beat_width f=%0d got=%0b%0b exp=00", f, bus.beat, bus.generate_next_sample); end
    end
    bus.play_button = 1'b1; step(); bus.play_button = 1'b0;
    vectors++; if (bus.play !== 1'b0) begin errors++; $display("FAIL pause_play got=%0b exp=0", bus.play); end
    for (int f = 1; f <= 3; f++) begin
      bus.new_frame = 1'b1; step(); bus.new_frame = 1'b0;
      vectors++; if (bus.beat !== 1'b0) begin errors++; $display("FAIL pause_beat f=%0d got=1 exp=0", f); end
      step();
    end
    bus.play_button = 1'b1; step(); bus.play_button = 1'b0;
    vectors++; if (bus.play !== 1'b1) begin errors++; $display("FAIL resume_play got=%0b exp=1", bus.play); end
    for (int f = 1; f <= 4; f++) begin
      bus.new_frame = 1'b1; step(); bus.new_frame = 1'b0;
      vectors++; if (bus.beat !== (f == 4)) begin errors++; $display("FAIL resume_beat f=%0d got=%0b exp=%0b", f, bus.beat, f == 4); end
      step();
    end
  endtask

  task automatic test_mix();
    set_voices(30000, 30000, -100, 0);
    bus.voice_ready = 4'hF; step(); bus.voice_ready = 4'h0; step();
    pulse_frame();
    vectors++; if (bus.sample_out !== 16'sd32767) begin errors++; $display("FAIL mix_sat_pos got=%0d exp=32767", bus.sample_out); end
    set_voices(-20000, -20000, -20000, -20000);
    bus.voice_ready = 4'hF; step(); bus.voice_ready = 4'h0; step();
    pulse_frame();
    vectors++; if (bus.sample_out !== -16'sd32768) begin errors++; $display("FAIL mix_sat_neg got=%0d exp=-32768", bus.sample_out); end
    pulse_frame();
    vectors++; if (bus.sample_out !== -16'sd32768) begin errors++; $display("FAIL mix_underrun got=%0d exp=-32768", bus.sample_out); end
    set_voices(100, 200, -50, 7);
    bus.voice_ready = 4'hF; step(); bus.voice_ready = 4'h0; step();
    pulse_frame();
    vectors++; if (bus.sample_out !== 16'sd257) begin errors++; $display("FAIL mix_plain got=%0d exp=257", bus.sample_out); end
    set_voices(1, 2, 3, 4);
    bus.voice_ready = 4'b0011; step(); bus.voice_ready = 4'h0; step();
    pulse_frame();
    vectors++; if (bus.sample_out !== 16'sd257) begin errors++; $display("FAIL mix_partial got=%0d exp=257", bus.sample_out); end
    set_voices(10, 2, 3, 4);
    bus.voice_ready = 4'b0001; step();
    bus.voice_ready = 4'b1100; step(); bus.voice_ready = 4'h0; step();
    pulse_frame();
    vectors++; if (bus.sample_out !== 16'sd19) begin errors++; $display("FAIL mix_overwrite got=%0d exp=19", bus.sample_out); end
  endtask

  task automatic test_same_cycle();
    set_voices(-5, -6, -7, -8);
    bus.voice_ready = 4'hF; bus.new_frame = 1'b1; step();
    bus.voice_ready = 4'h0; bus.new_frame = 1'b0;
    vectors++; if (bus.new_sample_generated !== 1'b1) begin errors++; $display("FAIL same_nsg got=0 exp=1"); end
    step();
    vectors++; if (bus.sample_out !== 16'sd19) begin errors++; $display("FAIL same_hold got=%0d exp=19", bus.sample_out); end
    pulse_frame();
    vectors++; if (bus.sample_out !== -16'sd26) begin errors++; $display("FAIL same_pending got=%0d exp=-26", bus.sample_out); end
  endtask

  task automatic test_next_wrap();
    bus.song_select = 5'd15; bus.song_select_valid = 1'b1; step(); bus.song_select_valid = 1'b0;
    vectors++; if (bus.reset_player !== 1'b1 || bus.song !== 5'd15) begin errors++; $display("FAIL sel15 rp=%0b song=%0d exp rp=1 song=15", bus.reset_player, bus.song); end
    step();
    vectors++; if (bus.reset_player !== 1'b0 || bus.play !== 1'b1) begin errors++; $display("FAIL sel15_after rp=%0b play=%0b exp 0 1", bus.reset_player, bus.play); end
    bus.next_button = 1'b1; step(); bus.next_button = 1'b0;
    vectors++; if (bus.reset_player !== 1'b1 || bus.song !== 5'd0) begin errors++; $display("FAIL next_wrap rp=%0b song=%0d exp rp=1 song=0", bus.reset_player, bus.song); end
    step();
    vectors++; if (bus.reset_player !== 1'b0 || bus.play !== 1'b0 || bus.song !== 5'd0) begin errors++; $display("FAIL next_after rp=%0b play=%0b song=%0d exp 0 0 0", bus.reset_player, bus.play, bus.song); end
  endtask

  task automatic test_loop();
    bus.song_select = 5'd3; bus.song_select_valid = 1'b1; step(); bus.song_select_valid = 1'b0; step();
    vectors++; if (bus.play !== 1'b1 || bus.song !== 5'd3) begin errors++; $display("FAIL loop_start play=%0b song=%0d exp 1 3", bus.play, bus.song); end
    bus.loop_en = 1'b1; bus.song_done = 1'b1; step(); bus.song_done = 1'b0;
    vectors++; if (bus.reset_player !== 1'b1 || bus.song !== 5'd3) begin errors++; $display("FAIL loop_rst rp=%0b song=%0d exp 1 3", bus.reset_player, bus.song); end
    step();
    vectors++; if (bus.reset_player !== 1'b0 || bus.play !== 1'b1 || bus.song !== 5'd3) begin errors++; $display("FAIL loop_after rp=%0b play=%0b song=%0d exp 0 1 3", bus.reset_player, bus.play, bus.song); end
    bus.loop_en = 1'b0; bus.song_done = 1'b1; step(); bus.song_done = 1'b0;
    vectors++; if (bus.reset_player !== 1'b1 || bus.song !== 5'd4) begin errors++; $display("FAIL done_rst rp=%0b song=%0d exp 1 4", bus.reset_player, bus.song); end
    step();
    vectors++; if (bus.play !== 1'b0 || bus.song !== 5'd4) begin errors++; $display("FAIL done_after play=%0b song=%0d exp 0 4", bus.play, bus.song); end
    bus.song_done = 1'b1; step(); bus.song_done = 1'b0;
    vectors++; if (bus.reset_player !== 1'b0 || bus.song !== 5'd4) begin errors++; $display("FAIL done_idle rp=%0b song=%0d exp 0 4", bus.reset_player, bus.song); end
  endtask

  task automatic test_priority();
    bus.song_select = 5'd20; bus.song_select_valid = 1'b1; bus.next_button = 1'b1; step();
    bus.song_select_valid = 1'b0; bus.next_button = 1'b0;
    vectors++; if (bus.reset_player !== 1'b0 || bus.song !== 5'd4) begin errors++; $display("FAIL prio_invalid rp=%0b song=%0d exp 0 4", bus.reset_player, bus.song); end
    step();
    vectors++; if (bus.reset_player !== 1'b0 || bus.play !== 1'b0) begin errors++; $display("FAIL prio_invalid2 rp=%0b play=%0b exp 0 0", bus.reset_player, bus.play); end
    bus.song_select = 5'd7; bus.song_select_valid = 1'b1; bus.play_button = 1'b1; step();
    bus.song_select_valid = 1'b0; bus.play_button = 1'b0;
    vectors++; if (bus.reset_player !== 1'b1 || bus.song !== 5'd7) begin errors++; $display("FAIL prio_sel rp=%0b song=%0d exp 1 7", bus.reset_player, bus.song); end
    step();
    vectors++; if (bus.play !== 1'b1) begin errors++; $display("FAIL prio_sel_play got=%0b exp=1", bus.play); end
    bus.next_button = 1'b1; bus.play_button = 1'b1; step();
    bus.next_button = 1'b0; bus.play_button = 1'b0;
    vectors++; if (bus.reset_player !== 1'b1 || bus.song !== 5'd8) begin errors++; $display("FAIL prio_next rp=%0b song=%0d exp 1 8", bus.reset_player, bus.song); end
    step();
    vectors++; if (bus.play !== 1'b0) begin errors++; $display("FAIL prio_next_play got=%0b exp=0", bus.play); end
  endtask

  task automatic test_held_frame();
    int gens = 0;
    int nsgs = 0;
    bus.new_frame = 1'b1;
    for (int c = 0; c < 50; c++) begin
      step();
      if (bus.generate_next_sample === 1'b1) gens++;
      if (bus.new_sample_generated === 1'b1) nsgs++;
    end
    bus.new_frame = 1'b0;
    step();
    vectors++; if (gens !== 1) begin errors++; $display("FAIL held_gen_count got=%0d exp=1", gens); end
    vectors++; if (nsgs !== 1) begin errors++; $display("FAIL held_nsg_count got=%0d exp=1", nsgs); end
    vectors++; if (bus.sample_out !== -16'sd26) begin errors++; $display("FAIL held_sample got=%0d exp=-26", bus.sample_out); end
  endtask

  task automatic test_reset_mid();
    bus.play_button = 1'b1; step(); bus.play_button = 1'b0;
    vectors++; if (bus.play !== 1'b1) begin errors++; $display("FAIL mid_play got=%0b exp=1", bus.play); end
    reset = 1'b0; step();
    vectors++; if (bus.play !== 1'b0 || bus.song !== 5'd0) begin errors++; $display("FAIL mid_reset play=%0b song=%0d exp 0 0", bus.play, bus.song); end
    vectors++; if (bus.sample_out !== 16'sd0) begin errors++; $display("FAIL mid_reset_sample got=%0d exp=0", bus.sample_out); end
    reset = 1'b1; step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset                 = 1'b0;
    bus.play_button       = 1'b0;
    bus.next_button       = 1'b0;
    bus.song_select       = '0;
    bus.song_select_valid = 1'b0;
    bus.loop_en           = 1'b0;
    bus.song_done         = 1'b0;
    bus.new_frame         = 1'b0;
    bus.voice_sample      = '0;
    bus.voice_ready       = '0;
    step();
    test_reset();
    test_beat();
    test_mix();
    test_same_cycle();
    test_next_wrap();
    test_loop();
    test_priority();
    test_held_frame();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
